// File: rtl/ctrl_burst_cas.sv
// Column-command (CAS) stage of the DDR4 controller: enforces tRCD and tCCD_S/L, issues READ/WRITE strobes.
// Optional CAS_DATA_WINDOW_EN builds the CL/CWL shift registers that drive rd_data_start/wr_data_start.

package ddr_pkg;
    typedef enum logic [2:0] {
        NOP_R = 3'd0,
        RD_R  = 3'd1,
        WR_R  = 3'd2,
        PRE_R = 3'd3,
        REF_R = 3'd4
    } req_type_e;
endpackage

module ctrl_burst_cas #(
    parameter int T_RCD   = 16,
    parameter int T_CCD_S = 4,
    parameter int T_CCD_L = 6,
    parameter int CL      = 16,
    parameter int CWL     = 12
) (
    input  logic        CK_t,
    input  logic        reset,
    input  logic        act_rdy,
    input  logic        no_act_rdy,
    input  logic [2:0]  act_rw,
    input  logic [1:0]  bg_addr,
    input  logic [1:0]  ba_addr,
    input  logic [9:0]  col_addr,
    output logic        cas_rdy,
    output logic [2:0]  cas_req,
    output logic [13:0] cas_reg,
    output logic        cas_idle,
    output logic        rd_data_start,
    output logic        wr_data_start,
    output logic        ovf
);
    import ddr_pkg::*;

    if (T_RCD < 2 || CL < 2 || CWL < 2) begin : g_bad_params
        $error("ctrl_burst_cas: T_RCD, CL and CWL must all be >= 2");
    end

    typedef enum logic [1:0] {CAS_IDLE, CAS_TRCD, CAS_TCCD, CAS_ISSUE} cas_state_e;

    typedef struct packed {
        logic [2:0] rw;
        logic [1:0] bg;
        logic [1:0] ba;
        logic [9:0] col;
    } cas_cmd_t;

    typedef struct packed {
        logic     is_act;
        cas_cmd_t cmd;
    } req_t;

    localparam logic [7:0] TRCD_M1   = 8'(T_RCD - 1);
    localparam logic [7:0] TCCD_S_M1 = 8'(T_CCD_S - 1);
    localparam logic [7:0] TCCD_L_M1 = 8'(T_CCD_L - 1);

    cas_state_e state_q, state_d;
    cas_cmd_t   cur_q;
    req_t       pend_q;
    logic       pend_valid_q;
    logic [7:0] pend_age_q;
    logic [7:0] trcd_cnt_q;
    logic [7:0] since_cas_q;

    req_t       in_req, src_req;
    logic       req_valid, dispatch, take_in, pend_pop, skid_wr, ovf_set;
    logic [7:0] src_age, disp_age, tccd_m1;

    // NOTE: every signal driven here gets a default first so no path through the case leaves one unassigned (no latch).
    always_comb begin
        in_req    = '{is_act: act_rdy, cmd: '{rw: act_rw, bg: bg_addr, ba: ba_addr, col: col_addr}};
        req_valid = (act_rdy || no_act_rdy) && (act_rw == RD_R || act_rw == WR_R);
        tccd_m1   = (cur_q.bg == cas_reg[13:12]) ? TCCD_L_M1 : TCCD_S_M1;
        state_d   = state_q;
        dispatch  = 1'b0;
        take_in   = 1'b0;
        pend_pop  = 1'b0;
        src_req   = in_req;
        src_age   = 8'd0;

        case (state_q)
            CAS_IDLE: begin
                if (req_valid) begin
                    dispatch = 1'b1;
                    take_in  = 1'b1;
                end
            end
            CAS_TRCD: begin
                if (trcd_cnt_q + 8'd1 >= TRCD_M1) state_d = CAS_TCCD;
            end
            CAS_TCCD: begin
                // since_cas reads 0 in the ISSUE cycle, so the CAS lands one cycle after this test passes.
                if (since_cas_q >= tccd_m1) state_d = CAS_ISSUE;
            end
            CAS_ISSUE: begin
                state_d = CAS_IDLE;
                if (pend_valid_q) begin
                    dispatch = 1'b1;
                    pend_pop = 1'b1;
                    src_req  = pend_q;
                    src_age  = pend_age_q;
                end else if (req_valid) begin
                    dispatch = 1'b1;
                    take_in  = 1'b1;
                end
            end
            default: state_d = CAS_IDLE;
        endcase

        // disp_age is the request's age (cycles since its ACT) in the first cycle after dispatch.
        disp_age = (src_age == 8'hFF) ? 8'hFF : src_age + 8'd1;
        if (dispatch) begin
            state_d = (src_req.is_act && disp_age < TRCD_M1) ? CAS_TRCD : CAS_TCCD;
        end

        skid_wr = req_valid && !take_in && !pend_valid_q;
        ovf_set = req_valid && !take_in && pend_valid_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q      <= CAS_IDLE;
            pend_valid_q <= 1'b0;
            pend_age_q   <= 8'd0;
            trcd_cnt_q   <= 8'd0;
            since_cas_q  <= 8'hFF;
            cas_req      <= 3'd0;
            cas_reg      <= 14'd0;
            ovf          <= 1'b0;
        end else begin
            state_q <= state_d;

            if (skid_wr)       pend_valid_q <= 1'b1;
            else if (pend_pop) pend_valid_q <= 1'b0;

            if (skid_wr)                                 pend_age_q <= 8'd1;
            else if (pend_valid_q && pend_age_q != 8'hFF) pend_age_q <= pend_age_q + 8'd1;

            if (dispatch)                  trcd_cnt_q <= disp_age;
            else if (state_q == CAS_TRCD)  trcd_cnt_q <= trcd_cnt_q + 8'd1;

            if (state_d == CAS_ISSUE)      since_cas_q <= 8'd0;
            else if (since_cas_q != 8'hFF) since_cas_q <= since_cas_q + 8'd1;

            if (state_d == CAS_ISSUE) begin
                cas_req <= cur_q.rw;
                cas_reg <= {cur_q.bg, cur_q.ba, cur_q.col};
            end

            if (ovf_set) ovf <= 1'b1;
        end
    end

    // NOTE: request payload registers carry no reset; they are only read while their valid/state qualifier is set.
    always_ff @(posedge CK_t) begin
        if (dispatch) cur_q  <= src_req.cmd;
        if (skid_wr)  pend_q <= in_req;
    end

    assign cas_rdy  = (state_q == CAS_ISSUE);
    assign cas_idle = (state_q == CAS_IDLE) && !pend_valid_q;

`ifdef CAS_DATA_WINDOW_EN
    logic [CL-1:0]  rd_sr;
    logic [CWL-1:0] wr_sr;

    // One bit per outstanding window so overlapping CAS latencies are tracked independently.
    always_ff @(posedge CK_t) begin
        if (reset) begin
            rd_sr <= '0;
            wr_sr <= '0;
        end else begin
            rd_sr <= {rd_sr[CL-2:0],  cas_rdy && (cas_req == RD_R)};
            wr_sr <= {wr_sr[CWL-2:0], cas_rdy && (cas_req == WR_R)};
        end
    end

    assign rd_data_start = rd_sr[CL-1];
    assign wr_data_start = wr_sr[CWL-1];
`else
    assign rd_data_start = 1'b0;
    assign wr_data_start = 1'b0;
`endif

endmodule
